spi_mstr_param: RTL
===================

SPI_MSTR_PARAM -- requirements
Module: spi_mstr_param

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 16, SHALL set the frame length in bits (range 4..32).
REQ-003 Parameter SCLK_HALF, default 16, SHALL set the SCLK half-period in clk cycles (range 2..256).
REQ-004 Parameter NUM_SS, default 1, SHALL set the number of slave-select lines (range 1..8).
REQ-005 Ports SHALL be:
  clk  in  1  system clock
  rst  in  1  asynchronous active-high reset
  wrt  in  1  start request, one-cycle pulse
  cmd  in  DATA_W  frame to transmit, MSB first
  mode  in  2  {CPOL,CPHA}, sampled at accept
  ss_sel  in  3  target slave index, sampled at accept
  MISO  in  1  serial data in
  SCLK  out  1  serial clock
  MOSI  out  1  serial data out
  SS_n  out  NUM_SS  active-low slave selects
  rd_data  out  DATA_W  last received frame
  busy  out  1  transfer in progress
  done  out  1  one-cycle completion pulse

Function
REQ-006 FSM states SHALL be IDLE, SETUP, XFER, HOLD; IDLE->SETUP on accepted wrt; SETUP->XFER after SCLK_HALF cycles; XFER->HOLD after 2*DATA_W half-periods; HOLD->IDLE after SCLK_HALF cycles.
REQ-007 wrt SHALL be accepted only in IDLE; wrt while busy=1 SHALL be ignored with no effect on the current frame.
REQ-008 On accept, cmd, mode and ss_sel SHALL be latched; later changes SHALL not affect the frame.
REQ-009 ss_sel >= NUM_SS SHALL select no slave (all SS_n high) while the transfer otherwise runs normally.
REQ-010 SS_n[ss_sel] SHALL go low the cycle after accept and stay low through SETUP, XFER and HOLD; all other SS_n bits SHALL stay high.
REQ-011 SCLK SHALL equal CPOL in IDLE, SETUP and HOLD, and SHALL toggle every SCLK_HALF cycles in XFER, giving exactly DATA_W full periods.
REQ-012 CPHA=0: MOSI SHALL present bit DATA_W-1 from SETUP entry, MISO SHALL be sampled on each leading edge, MOSI SHALL advance on each trailing edge except the last.
REQ-013 CPHA=1: MOSI SHALL advance on each leading edge (first leading edge presents bit DATA_W-1), and MISO SHALL be sampled on each trailing edge.
REQ-014 Sampling SHALL occur in the clk cycle in which SCLK changes; received bits SHALL shift in MSB first into an internal register.
REQ-015 rd_data SHALL update from the internal register only at the HOLD->IDLE transition and SHALL otherwise hold its value.
REQ-016 done SHALL pulse high for exactly one cycle, the same cycle SS_n returns high and rd_data updates.
REQ-017 busy SHALL be high from the cycle after accept through the done cycle inclusive and low otherwise.
REQ-018 Total SS_n low time SHALL be (2*DATA_W+2)*SCLK_HALF clk cycles.
REQ-019 MOSI SHALL be 0 in IDLE.
REQ-020 A wrt in the done cycle SHALL be ignored; a wrt in the cycle after done SHALL be accepted, giving at least one SS_n-high cycle between frames.

Reset
REQ-021 Asserting rst SHALL immediately force state=IDLE, SS_n all ones, SCLK=0, MOSI=0, busy=0, done=0, rd_data=0, and clear the internal shift registers.
REQ-022 Reset during a transfer SHALL abort the frame with no done pulse; after release SCLK SHALL take the CPOL of the next accepted frame only.

Verification
REQ-023 DATA_W=16, SCLK_HALF=4, mode=00, cmd=16'hA55A, MISO looped to MOSI -> rd_data=16'hA55A, SS_n low 136 cycles, 16 rising SCLK edges, one done pulse.
REQ-024 Same setup with mode=11 and cmd=16'h1234 -> SCLK idles high, MOSI changes on falling edges, rd_data=16'h1234.
REQ-025 mode=01, MISO tied 1 -> rd_data=16'hFFFF; mode=10, MISO tied 0 -> rd_data=16'h0000; MOSI matches cmd on every sample edge.
REQ-026 NUM_SS=4, ss_sel=2, then ss_sel=5 -> first frame drives only SS_n[2] low; second frame keeps SS_n=4'b1111 yet still pulses done.
REQ-027 wrt re-pulsed mid-frame with different cmd -> ignored, rd_data and MOSI reflect first cmd; back-to-back wrt in the cycle after done -> second frame accepted.
REQ-028 rst asserted at bit 7 of a frame -> outputs reach reset values in the same cycle, no done pulse; the next frame after release completes correctly.

Source files
------------

// File: rtl/spi_mstr_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_param
// Description : Parameterised SPI master. Single frame of DATA_W bits, MSB
//               first, any of the four SPI modes selected per frame, up to
//               eight active-low slave selects.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W     frame length in bits                    (4..32)
//   SCLK_HALF  SCLK half-period in clk cycles          (2..256)
//   NUM_SS     number of slave-select lines            (1..8)
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   wrt        start request, one-cycle pulse, honoured only when idle
//   cmd        frame to transmit (MSB first), latched at accept
//   mode       {CPOL,CPHA}, latched at accept
//   ss_sel     target slave index, latched at accept (>= NUM_SS: none)
//   MISO       serial data in
//   SCLK       serial clock
//   MOSI       serial data out
//   SS_n       active-low slave selects
//   rd_data    last complete received frame
//   busy       transfer in progress (through the done cycle)
//   done       one-cycle completion pulse
// ============================================================================
module spi_mstr_param #(
  parameter int DATA_W    = 16,
  parameter int SCLK_HALF = 16,
  parameter int NUM_SS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [1:0]        mode,
  input  logic [2:0]        ss_sel,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  if (DATA_W < 4 || DATA_W > 32) begin : g_chk_data_w
    $error("spi_mstr_param: DATA_W out of range 4..32");
  end
  if (SCLK_HALF < 2 || SCLK_HALF > 256) begin : g_chk_sclk_half
    $error("spi_mstr_param: SCLK_HALF out of range 2..256");
  end
  if (NUM_SS < 1 || NUM_SS > 8) begin : g_chk_num_ss
    $error("spi_mstr_param: NUM_SS out of range 1..8");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int C_DIV_W  = $clog2(SCLK_HALF);
  localparam int C_HALF_W = $clog2(2 * DATA_W);

  localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(SCLK_HALF - 1);
  localparam logic [C_HALF_W-1:0] C_HALF_LAST = C_HALF_W'(2 * DATA_W - 1);
  localparam logic [C_DIV_W-1:0]  C_DIV_ONE   = C_DIV_W'(1);
  localparam logic [C_HALF_W-1:0] C_HALF_ONE  = C_HALF_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [C_DIV_W-1:0]  r_div;    // clk cycles within the current half-period
  logic [C_HALF_W-1:0] r_half;   // index of the current SCLK half-period in XFER
  logic                r_cpha;   // latched CPHA; CPOL lives in the SCLK register
  logic [DATA_W-1:0]   r_tx;     // bits still to be presented on MOSI
  logic [DATA_W-1:0]   r_rx;     // receive shift register

  // --------------------------------------------------------------------------
  // Slave-select decode: an index that matches no line leaves all high
  // --------------------------------------------------------------------------
  logic [NUM_SS-1:0] w_ss_dec;

  for (genvar i = 0; i < NUM_SS; i++) begin : g_ss_dec
    assign w_ss_dec[i] = (ss_sel != 3'(i));
  end

  // --------------------------------------------------------------------------
  // SCLK edge bookkeeping
  //
  // SCLK edge k (k = 0 .. 2*DATA_W-1) happens on the clk edge that starts
  // half-period k of XFER: edge 0 on leaving SETUP, the rest at the end of
  // each half-period except the last. Even k are leading edges, odd k are
  // trailing edges; edge 2*DATA_W-1 returns SCLK to CPOL for the final
  // half-period, so SCLK is already idle when HOLD begins.
  // --------------------------------------------------------------------------
  logic                w_div_end;
  logic                w_accept;
  logic                w_edge;
  logic [C_HALF_W-1:0] w_edge_idx;
  logic                w_lead;
  logic                w_last;
  logic                w_sample;
  logic                w_advance;

  always_comb begin
    w_div_end  = (r_div == C_DIV_LAST);
    // A wrt coinciding with done is dropped so frames are separated by at
    // least one cycle with every select high.
    w_accept   = (r_state == S_IDLE) && wrt && !done;
    w_edge     = w_div_end &&
                 ((r_state == S_SETUP) ||
                  ((r_state == S_XFER) && (r_half != C_HALF_LAST)));
    w_edge_idx = (r_state == S_SETUP) ? '0 : (r_half + C_HALF_ONE);
    w_lead     = ~w_edge_idx[0];
    w_last     = (w_edge_idx == C_HALF_LAST);
    // CPHA=0: sample on leading, shift out on trailing (MSB already on MOSI).
    // CPHA=1: shift out on leading, sample on trailing.
    w_sample   = w_edge && (r_cpha ? ~w_lead : w_lead);
    w_advance  = w_edge && (r_cpha ? w_lead : (~w_lead && ~w_last));
  end

  // --------------------------------------------------------------------------
  // Main FSM and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_half  <= '0;
      r_cpha  <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      SS_n    <= '1;
      rd_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      // MISO is captured in the same clk cycle that SCLK changes.
      if (w_sample) begin
        r_rx <= {r_rx[DATA_W-2:0], MISO};
      end

      if (w_advance) begin
        MOSI <= r_tx[DATA_W-1];
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end

      if (w_edge) begin
        SCLK <= ~SCLK;
      end

      case (r_state)
        S_IDLE: begin
          // busy stays high through the done cycle and drops on the next edge
          busy  <= 1'b0;
          r_div <= '0;
          if (w_accept) begin
            r_state <= S_SETUP;
            busy    <= 1'b1;
            SS_n    <= w_ss_dec;
            SCLK    <= mode[1];
            r_cpha  <= mode[0];
            r_rx    <= '0;
            if (mode[0]) begin
              // First leading edge presents the MSB.
              MOSI <= 1'b0;
              r_tx <= cmd;
            end else begin
              // MSB is set up a full half-period before the first edge.
              MOSI <= cmd[DATA_W-1];
              r_tx <= {cmd[DATA_W-2:0], 1'b0};
            end
          end
        end

        S_SETUP: begin
          r_div <= w_div_end ? '0 : (r_div + C_DIV_ONE);
          if (w_div_end) begin
            r_state <= S_XFER;
            r_half  <= '0;
          end
        end

        S_XFER: begin
          r_div <= w_div_end ? '0 : (r_div + C_DIV_ONE);
          if (w_div_end) begin
            if (r_half == C_HALF_LAST) begin
              r_state <= S_HOLD;
            end else begin
              r_half <= r_half + C_HALF_ONE;
            end
          end
        end

        S_HOLD: begin
          r_div <= w_div_end ? '0 : (r_div + C_DIV_ONE);
          if (w_div_end) begin
            r_state <= S_IDLE;
            SS_n    <= '1;
            done    <= 1'b1;
            rd_data <= r_rx;
            MOSI    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
